// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned FIFO_W     = 2 * XLEN;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_STEP           = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_KILL  = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry synchronous FIFO of {pc, instr}; flush empties it in one cycle.
module ifu_fifo
    import ifu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [FIFO_W-1:0] wdata,
    output logic [FIFO_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    logic [FIFO_W-1:0] mem [FIFO_DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory request, 2-deep prefetch buffer,
// branch redirect that squashes buffered and in-flight instructions.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid
);

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [CNT_W-1:0]  fifo_count;
    logic [FIFO_W-1:0] fifo_head;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Next state and request generation; a redirect overrides everything else
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        imem_req   = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        if (branch_taken) begin
            fifo_flush = 1'b1;
            fetch_pc_d = branch_target & PC_ALIGN_MASK;
        end

        case (state_q)
            ST_FETCH: begin
                if (!branch_taken && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (branch_taken) begin
                    state_d = imem_rvalid ? ST_FETCH : ST_KILL;
                end else if (imem_rvalid) begin
                    fifo_push = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (imem_rvalid) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        if (rst) imem_req = 1'b0;
    end

    assign imem_addr        = fetch_pc_q;
    assign push_entry.pc    = req_pc_q;
    assign push_entry.instr = imem_rdata;

    assign instr_valid = (fifo_count != '0) && !rst;
    assign fifo_pop    = instr_valid && PCWrite && !branch_taken;
    assign head        = fetch_entry_t'(fifo_head);
    assign instr_out   = instr_valid ? head.instr : NOP_INSTR;
    assign pc_out      = instr_valid ? head.pc    : '0;

    ifu_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (FIFO_W'(push_entry)),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: buffered instructions, next fetch address, in-flight request
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fpc  = RST_PC;
    bit          m_pend = 1'b0;
    bit          m_live = 1'b0;
    logic [31:0] m_ppc  = '0;

    // Memory environment
    bit          env_busy  = 1'b0;
    int          env_cnt   = 0;
    logic [31:0] env_addr  = '0;
    int          env_delay = 1;
    bit          stray_en  = 1'b0;
    logic        nxt_rv    = 1'b0;
    logic [31:0] nxt_data  = '0;

    always @(negedge clk) begin
        bit   exp_valid;
        bit   exp_req;
        bit   resp;
        ent_t e;
        exp_valid = !rst && (mq.size() != 0);
        exp_req   = !rst && !m_pend && (mq.size() < 2) && !branch_taken;

        chk("valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("instr", instr_out, mq[0].instr);
            chk("pc", pc_out, mq[0].pc);
        end else begin
            chk("instr_nop", instr_out, NOP);
            chk("pc_zero", pc_out, 32'h0);
        end
        chk("req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("addr", imem_addr, m_fpc);

        if (rst) begin
            mq.delete();
            m_fpc  = RST_PC;
            m_pend = 1'b0;
        end else begin
            resp = m_pend && imem_rvalid;
            if (branch_taken) begin
                mq.delete();
                m_fpc = branch_target & 32'hFFFF_FFFC;
                if (m_pend) begin
                    if (resp) m_pend = 1'b0;
                    else      m_live = 1'b0;
                end
            end else begin
                if (exp_valid && PCWrite) void'(mq.pop_front());
                if (resp) begin
                    m_pend = 1'b0;
                    if (m_live) begin
                        e.pc = m_ppc;
                        e.instr = imem_rdata;
                        mq.push_back(e);
                    end
                end
                if (exp_req && imem_ready) begin
                    m_pend = 1'b1;
                    m_live = 1'b1;
                    m_ppc  = m_fpc;
                    m_fpc  = m_fpc + 32'd4;
                end
            end
        end

        nxt_rv = 1'b0;
        if (rst) begin
            env_busy = 1'b0;
        end else begin
            if (imem_req && imem_ready) begin
                env_busy = 1'b1;
                env_addr = imem_addr;
                env_cnt  = (env_delay == 0) ? int'($urandom_range(1, 3)) : env_delay;
            end
            if (env_busy) begin
                env_cnt--;
                if (env_cnt <= 0) begin
                    nxt_rv   = 1'b1;
                    nxt_data = mem_word(env_addr);
                    env_busy = 1'b0;
                end
            end else if (stray_en && ($urandom_range(0, 9) == 0)) begin
                nxt_rv   = 1'b1;
                nxt_data = $urandom;
            end
        end
    end

    task automatic drive(input logic r, input logic pcw, input logic rdy,
                         input logic bt, input logic [31:0] tgt, input logic frc);
        @(posedge clk);
        #1;
        rst           = r;
        PCWrite       = pcw;
        imem_ready    = rdy;
        branch_taken  = bt;
        branch_target = tgt;
        if (frc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = nxt_rv;
            imem_rdata  = nxt_rv ? nxt_data : $urandom;
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Advance with PCWrite=1/ready=1 until a valid instruction appears; its pc must match
    task automatic wait_valid_pc(input string name, input logic [31:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
                chk(name, pc_out, exp_pc);
            end
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no valid instruction within budget, expected pc %h", name, exp_pc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; PCWrite = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_rvalid = 1'b0; imem_rdata = '0;

        // Straight-line fetch, single-cycle memory
        env_delay = 1; stray_en = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_pc", pc_out, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("seq_req0", 32'(imem_req), 32'h1);
        chk("seq_addr0", imem_addr, RST_PC);
        chk("seq_valid_c0", 32'(instr_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("seq_valid_c1", 32'(instr_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("seq_valid_c2", 32'(instr_valid), 32'h1);
        chk("seq_pc0", pc_out, 32'h0);
        chk("seq_instr0", instr_out, mem_word(32'h0));
        wait_valid_pc("seq_pc4", 32'h4);
        wait_valid_pc("seq_pc8", 32'h8);
        wait_valid_pc("seq_pc12", 32'hC);

        // Stall fills the buffer, release drains it in order
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
        end
        chk("stall_req", 32'(imem_req), 32'h0);
        chk("stall_valid", 32'(instr_valid), 32'h1);
        chk("stall_pc", pc_out, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("drain_pc0", pc_out, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("drain_valid4", 32'(instr_valid), 32'h1);
        chk("drain_pc4", pc_out, 32'h4);
        wait_valid_pc("drain_pc8", 32'h8);

        // Redirect while waiting on memory
        env_delay = 2;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1003, 1'b0);
        @(negedge clk);
        chk("kill_req_bt", 32'(imem_req), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("kill_late_req", 32'(imem_req), 32'h0);
        chk("kill_late_valid", 32'(instr_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("kill_req", 32'(imem_req), 32'h1);
        chk("kill_addr", imem_addr, 32'h0000_1000);
        wait_valid_pc("kill_first_pc", 32'h0000_1000);

        // Redirect coincident with a response and a non-empty buffer
        env_delay = 1;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        @(negedge clk);
        chk("flush_pre_valid", 32'(instr_valid), 32'h1);
        chk("flush_pre_rv", 32'(imem_rvalid), 32'h1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("flush_valid", 32'(instr_valid), 32'h0);
        chk("flush_addr", imem_addr, 32'h0000_0200);
        wait_valid_pc("flush_first_pc", 32'h0000_0200);

        // Address wrap at the top of memory
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);
        chk("wrap_bt_req", 32'(imem_req), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_addr_zero", imem_addr, 32'h0);

        // Reset while waiting, stray response right after
        env_delay = 3;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("rstw_req", 32'(imem_req), 32'h1);
        chk("rstw_addr", imem_addr, RST_PC);
        chk("rstw_valid", 32'(instr_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rstw_valid2", 32'(instr_valid), 32'h0);

        // Randomized traffic
        env_delay = 0; stray_en = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            drive(1'b0 | ($urandom_range(0, 99) == 0),
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 6,
                  tgt, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
